// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: three-stage pipelined multiplier for any even WIDTH.
// Operands are reduced to sign + magnitude, the magnitudes are multiplied with
// a one-level Karatsuba split (three half-width products), and the sign is
// reapplied at the end. A valid/ready handshake with backpressure moves all
// stages together, and an opaque tag travels alongside each operation.
module karatsuba_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H  = WIDTH / 2;
  // The middle Karatsuba product needs two guard bits over a plain 2H product.
  localparam int PW = 2 * H + 2;

  logic advance;

  // Stage 1 state: magnitudes, product sign and tag.
  logic             v1;
  logic             neg1;
  logic [WIDTH-1:0] ma1;
  logic [WIDTH-1:0] mb1;
  logic [TAG_W-1:0] tag1;

  // Stage 2 state: the three partial products.
  logic             v2;
  logic             neg2;
  logic [2*H-1:0]   p0_2;
  logic [2*H-1:0]   p2_2;
  logic [PW-1:0]    pm_2;
  logic [TAG_W-1:0] tag2;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] ma_c;
  logic [WIDTH-1:0] mb_c;

  logic [H-1:0]     a0;
  logic [H-1:0]     a1;
  logic [H-1:0]     b0;
  logic [H-1:0]     b1;
  logic [H:0]       asum;
  logic [H:0]       bsum;
  logic [2*H-1:0]   p0_c;
  logic [2*H-1:0]   p2_c;
  logic [PW-1:0]    pm_c;

  logic [PW-1:0]      mid_c;
  logic [2*WIDTH-1:0] mag_c;
  logic [2*WIDTH-1:0] res_c;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Convert the incoming operands to sign flag plus unsigned magnitude.
  always_comb begin
    sa   = is_signed & A[WIDTH-1];
    sb   = is_signed & B[WIDTH-1];
    ma_c = sa ? -A : A;
    mb_c = sb ? -B : B;
  end

  // Karatsuba partial products: low*low, high*high and (sum)*(sum).
  always_comb begin
    a0   = ma1[H-1:0];
    a1   = ma1[WIDTH-1:H];
    b0   = mb1[H-1:0];
    b1   = mb1[WIDTH-1:H];
    asum = {1'b0, a0} + {1'b0, a1};
    bsum = {1'b0, b0} + {1'b0, b1};
    p0_c = {{H{1'b0}}, a0} * {{H{1'b0}}, b0};
    p2_c = {{H{1'b0}}, a1} * {{H{1'b0}}, b1};
    pm_c = {{(H + 1){1'b0}}, asum} * {{(H + 1){1'b0}}, bsum};
  end

  // Recombine the partial products into the magnitude and reapply the sign.
  always_comb begin
    mid_c = pm_2 - {2'b00, p0_2} - {2'b00, p2_2};
    mag_c = {p2_2, p0_2} + ({{(2 * WIDTH - PW){1'b0}}, mid_c} << H);
    res_c = neg2 ? -mag_c : mag_c;
  end

  // Stage 1 register: capture magnitudes and sign on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      neg1 <= 1'b0;
      ma1  <= '0;
      mb1  <= '0;
      tag1 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        neg1 <= sa ^ sb;
        ma1  <= ma_c;
        mb1  <= mb_c;
        tag1 <= in_tag;
      end
    end
  end

  // Stage 2 register: hold the three partial products.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      neg2 <= 1'b0;
      p0_2 <= '0;
      p2_2 <= '0;
      pm_2 <= '0;
      tag2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        neg2 <= neg1;
        p0_2 <= p0_c;
        p2_2 <= p2_c;
        pm_2 <= pm_c;
        tag2 <= tag1;
      end
    end
  end

  // Stage 3 register: final signed product, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        result  <= res_c;
        out_tag <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// tb_karatsuba_mult_pipe: scoreboard bench for the Karatsuba multiplier.
// A 32-bit instance covers directed corners, throughput, backpressure and
// reset; four 8-bit instances share an exhaustive operand sweep; 16- and
// 64-bit instances run a random mixed-mode sweep with random backpressure.
module tb_karatsuba_mult_pipe;

  localparam int W8_N    = 32768;
  localparam int SWEEP_N = 10000;

  localparam logic [31:0] CA [8] = '{32'hFFFFFFFF, 32'h00010000, 32'h00000000, 32'hFFFFFFFF,
                                     32'h80000000, 32'h80000000, 32'hFFFFFFFD, 32'h00000000};
  localparam logic [31:0] CB [8] = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'h80000000, 32'h00000001, 32'h00000005, 32'h80000000};
  localparam logic        CS [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [63:0] CR [8] = '{64'hFFFFFFFE00000001, 64'h0000000100000000,
                                     64'h0000000000000000, 64'h0000000000000001,
                                     64'h4000000000000000, 64'hFFFFFFFF80000000,
                                     64'hFFFFFFFFFFFFFFF1, 64'h0000000000000000};

  logic clk = 1'b0;
  logic reset;
  int   ntotal = 0;
  int   npass  = 0;

  // 32-bit instance signals and scoreboard ({tag, result}).
  logic        iv32, ir32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [3:0]  tg32, ot32;
  logic [63:0] res32;
  logic [67:0] q32 [$];

  // 16-bit and 64-bit sweep instances.
  logic         iv16, ir16, s16, ov16, or16, took16;
  logic [15:0]  a16, b16;
  logic [3:0]   tg16, ot16;
  logic [31:0]  res16;
  logic [35:0]  q16 [$];
  logic         iv64, ir64, s64, ov64, or64, took64;
  logic [63:0]  a64, b64;
  logic [3:0]   tg64, ot64;
  logic [127:0] res64;
  logic [131:0] q64 [$];

  // Four 8-bit instances run in lockstep; scoreboard entry is {tag, p3, p2, p1, p0}.
  logic        iv8, or8;
  logic [3:0]  ir8, ov8, s8;
  logic [7:0]  a8 [4];
  logic [7:0]  b8;
  logic [3:0]  tg8;
  logic [3:0]  ot8 [4];
  logic [15:0] res8 [4];
  logic [67:0] q8 [$];

  always #5 clk = ~clk;

  karatsuba_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .is_signed(s32), .in_tag(tg32), .out_valid(ov32), .out_ready(or32),
    .result(res32), .out_tag(ot32)
  );

  karatsuba_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .is_signed(s16), .in_tag(tg16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .out_tag(ot16)
  );

  karatsuba_mult_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
    .is_signed(s64), .in_tag(tg64), .out_valid(ov64), .out_ready(or64),
    .result(res64), .out_tag(ot64)
  );

  for (genvar g = 0; g < 4; g++) begin : g_w8
    karatsuba_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8[g]), .A(a8[g]), .B(b8),
      .is_signed(s8[g]), .in_tag(tg8), .out_valid(ov8[g]), .out_ready(or8),
      .result(res8[g]), .out_tag(ot8[g])
    );
  end

  // Reference product: extend both operands to 128 bits and multiply directly.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input int w, input logic s);
    logic signed [127:0] ea, eb, p;
    logic [127:0] mask;
    ea = {64'd0, a} << (128 - w);
    eb = {64'd0, b} << (128 - w);
    if (s) begin
      ea = ea >>> (128 - w);
      eb = eb >>> (128 - w);
    end else begin
      ea = ea >> (128 - w);
      eb = eb >> (128 - w);
    end
    p    = ea * eb;
    mask = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return p & mask;
  endfunction

  // Random operand biased toward zero, all-ones, the most negative value and friends.
  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] mask, v;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      4:       v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v & mask;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    ntotal++;
    if (ov32 !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", ov32);
    else npass++;
    ntotal++;
    if (res32 !== 64'd0) $display("[TB] FAIL reset_result: got %h, expected 0", res32);
    else npass++;
    ntotal++;
    if (ot32 !== 4'd0) $display("[TB] FAIL reset_out_tag: got %h, expected 0", ot32);
    else npass++;
    ntotal++;
    if ({ov8, ov16, ov64} !== 6'd0) $display("[TB] FAIL reset_other_valid: got %b, expected 000000", {ov8, ov16, ov64});
    else npass++;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    ntotal++;
    if (ir32 !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", ir32);
    else npass++;
  endtask

  task automatic test_corners();
    logic [67:0] e;
    or32 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      iv32 = 1'b1; a32 = CA[i]; b32 = CB[i]; s32 = CS[i]; tg32 = 4'(i);
      #1;
      if (iv32 && ir32) q32.push_back({tg32, 64'(ref_mul(64'(a32), 64'(b32), 32, s32))});
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        iv32 = 1'b0;
        #1;
        ntotal++;
        if (ov32 !== 1'(c == 3))
          $display("[TB] FAIL corner%0d_latency: out_valid %b at cycle %0d after accept, expected %b", i, ov32, c, c == 3);
        else npass++;
      end
      ntotal++;
      if ({ot32, res32} !== {4'(i), CR[i]})
        $display("[TB] FAIL corner%0d_value: got tag %h result %h, expected tag %h result %h", i, ot32, res32, 4'(i), CR[i]);
      else npass++;
      if (q32.size() != 0) begin
        e = q32.pop_front();
        ntotal++;
        if ({ot32, res32} !== e)
          $display("[TB] FAIL corner%0d_scoreboard: got %h, expected %h", i, {ot32, res32}, e);
        else npass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] e;
    int first = -1, last = -1, n = 0;
    or32 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        iv32 = 1'b1; a32 = $urandom(); b32 = $urandom(); s32 = c[0]; tg32 = 4'(c);
      end else iv32 = 1'b0;
      #1;
      if (ov32 && or32) begin
        ntotal++;
        if (q32.size() == 0) $display("[TB] FAIL b2b_extra: unexpected result %h tag %h", res32, ot32);
        else begin
          e = q32.pop_front();
          if ({ot32, res32} !== e) $display("[TB] FAIL b2b_value: got %h, expected %h", {ot32, res32}, e);
          else npass++;
        end
        if (first < 0) first = c;
        last = c;
        n++;
      end
      if (iv32 && ir32) q32.push_back({tg32, 64'(ref_mul(64'(a32), 64'(b32), 32, s32))});
    end
    ntotal++;
    if ((n != 8) || (first != 3) || (last != 10))
      $display("[TB] FAIL b2b_timing: %0d results in cycles %0d..%0d, expected 8 in cycles 3..10", n, first, last);
    else npass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] opa [5];
    logic [31:0] opb [5];
    logic [67:0] e;
    int k = 0, n = 0, stall = 0;
    bit stall_started = 0;
    for (int i = 0; i < 5; i++) begin
      opa[i] = $urandom();
      opb[i] = $urandom();
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (k < 5) begin
        iv32 = 1'b1; a32 = opa[k]; b32 = opb[k]; s32 = k[0]; tg32 = 4'(8 + k);
      end else iv32 = 1'b0;
      if (ov32 && !stall_started) begin
        stall_started = 1;
        stall = 4;
      end
      or32 = (stall == 0);
      #1;
      if (stall > 0) begin
        ntotal++;
        if (ir32 !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b during stall, expected 0", ir32);
        else npass++;
        ntotal++;
        if (q32.size() == 0) $display("[TB] FAIL bp_hold: result %h with nothing pending", res32);
        else if ({ot32, res32} !== q32[0])
          $display("[TB] FAIL bp_hold: got %h during stall, expected %h", {ot32, res32}, q32[0]);
        else npass++;
        stall--;
      end
      if (ov32 && or32) begin
        ntotal++;
        if (q32.size() == 0) $display("[TB] FAIL bp_extra: unexpected result %h tag %h", res32, ot32);
        else begin
          e = q32.pop_front();
          if ({ot32, res32} !== e) $display("[TB] FAIL bp_value: got %h, expected %h", {ot32, res32}, e);
          else npass++;
        end
        n++;
      end
      if (iv32 && ir32) begin
        q32.push_back({tg32, 64'(ref_mul(64'(a32), 64'(b32), 32, s32))});
        k++;
      end
    end
    ntotal++;
    if ((n != 5) || (q32.size() != 0) || !stall_started)
      $display("[TB] FAIL bp_count: %0d results, %0d pending, expected 5 and 0", n, q32.size());
    else npass++;
  endtask

  task automatic test_reset_mid();
    logic [67:0] e;
    bit seen = 0;
    or32 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      iv32 = 1'b1; a32 = $urandom() | 32'h1; b32 = $urandom() | 32'h1; s32 = c[0]; tg32 = 4'(3 + c);
      #1;
      if (iv32 && ir32) q32.push_back({tg32, 64'(ref_mul(64'(a32), 64'(b32), 32, s32))});
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    q32.delete();
    ntotal++;
    if ({ov32, ot32, res32} !== 69'd0)
      $display("[TB] FAIL rst_mid_clear: got valid %b tag %h result %h, expected all 0", ov32, ot32, res32);
    else npass++;
    repeat (6) begin
      @(posedge clk); #2;
      if (ov32 !== 1'b0) seen = 1;
    end
    ntotal++;
    if (seen) $display("[TB] FAIL rst_mid_discard: out_valid %b after reset, expected 0", seen);
    else npass++;
    @(posedge clk); #1;
    iv32 = 1'b1; a32 = 32'h12345678; b32 = 32'hFEDCBA98; s32 = 1'b1; tg32 = 4'hA;
    #1;
    if (iv32 && ir32) q32.push_back({tg32, 64'(ref_mul(64'(a32), 64'(b32), 32, s32))});
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      iv32 = 1'b0;
      #1;
      ntotal++;
      if (ov32 !== 1'(c == 3))
        $display("[TB] FAIL rst_mid_latency: out_valid %b at cycle %0d, expected %b", ov32, c, c == 3);
      else npass++;
    end
    ntotal++;
    if (q32.size() != 1) $display("[TB] FAIL rst_mid_value: %0d pending, expected 1", q32.size());
    else begin
      e = q32.pop_front();
      if ({ot32, res32} !== e) $display("[TB] FAIL rst_mid_value: got %h, expected %h", {ot32, res32}, e);
      else npass++;
    end
  endtask

  task automatic test_w8_exhaustive();
    logic [67:0] e;
    int sent = 0, got = 0, cyc = 0;
    or8 = 1'b1;
    while ((got < W8_N) && (cyc < W8_N + 100)) begin
      @(posedge clk); #1;
      if (sent < W8_N) begin
        iv8 = 1'b1; b8 = sent[7:0]; tg8 = sent[3:0];
        for (int g = 0; g < 4; g++) begin
          a8[g] = {g[1], sent[14:8]};
          s8[g] = g[0];
        end
      end else iv8 = 1'b0;
      #1;
      if (ov8[0] && or8) begin
        got++;
        if (q8.size() == 0) begin
          ntotal++;
          $display("[TB] FAIL w8_extra: unexpected result %h", res8[0]);
        end else begin
          e = q8.pop_front();
          for (int g = 0; g < 4; g++) begin
            ntotal++;
            if ({ov8[g], ot8[g], res8[g]} !== {1'b1, e[67:64], e[16*g +: 16]})
              $display("[TB] FAIL w8_sweep%0d: got valid %b tag %h result %h, expected 1 %h %h",
                       g, ov8[g], ot8[g], res8[g], e[67:64], e[16*g +: 16]);
            else npass++;
          end
        end
      end
      if (iv8 && ir8[0]) begin
        q8.push_back({tg8, 16'(ref_mul(64'(a8[3]), 64'(b8), 8, s8[3])),
                           16'(ref_mul(64'(a8[2]), 64'(b8), 8, s8[2])),
                           16'(ref_mul(64'(a8[1]), 64'(b8), 8, s8[1])),
                           16'(ref_mul(64'(a8[0]), 64'(b8), 8, s8[0]))});
        sent++;
      end
      cyc++;
    end
    iv8 = 1'b0;
    ntotal++;
    if ((got != W8_N) || (q8.size() != 0))
      $display("[TB] FAIL w8_count: %0d results, %0d pending, expected %0d and 0", got, q8.size(), W8_N);
    else npass++;
  endtask

  task automatic test_random_sweep();
    logic [35:0]  e16;
    logic [131:0] e64;
    int acc16 = 0, acc64 = 0, got16 = 0, got64 = 0, cyc = 0;
    took16 = 1'b0;
    took64 = 1'b0;
    while (((got16 < SWEEP_N) || (got64 < SWEEP_N)) && (cyc < 40000)) begin
      @(posedge clk); #1;
      if (!iv16 || took16) begin
        iv16 = (acc16 < SWEEP_N) && ($urandom_range(3) != 0);
        a16 = 16'(rand_operand(16)); b16 = 16'(rand_operand(16));
        s16 = 1'($urandom_range(1)); tg16 = 4'($urandom_range(15));
      end
      if (!iv64 || took64) begin
        iv64 = (acc64 < SWEEP_N) && ($urandom_range(3) != 0);
        a64 = rand_operand(64); b64 = rand_operand(64);
        s64 = 1'($urandom_range(1)); tg64 = 4'($urandom_range(15));
      end
      or16 = ($urandom_range(3) != 0);
      or64 = ($urandom_range(3) != 0);
      #1;
      took16 = iv16 && ir16;
      took64 = iv64 && ir64;
      if (ov16 && or16) begin
        ntotal++;
        got16++;
        if (q16.size() == 0) $display("[TB] FAIL w16_extra: unexpected result %h tag %h", res16, ot16);
        else begin
          e16 = q16.pop_front();
          if ({ot16, res16} !== e16) $display("[TB] FAIL w16_sweep: got %h, expected %h", {ot16, res16}, e16);
          else npass++;
        end
      end
      if (ov64 && or64) begin
        ntotal++;
        got64++;
        if (q64.size() == 0) $display("[TB] FAIL w64_extra: unexpected result %h tag %h", res64, ot64);
        else begin
          e64 = q64.pop_front();
          if ({ot64, res64} !== e64) $display("[TB] FAIL w64_sweep: got %h, expected %h", {ot64, res64}, e64);
          else npass++;
        end
      end
      if (took16) begin
        q16.push_back({tg16, 32'(ref_mul(64'(a16), 64'(b16), 16, s16))});
        acc16++;
      end
      if (took64) begin
        q64.push_back({tg64, ref_mul(a64, b64, 64, s64)});
        acc64++;
      end
      cyc++;
    end
    iv16 = 1'b0;
    iv64 = 1'b0;
    ntotal++;
    if ((got16 != SWEEP_N) || (q16.size() != 0))
      $display("[TB] FAIL w16_count: %0d results, %0d pending, expected %0d and 0", got16, q16.size(), SWEEP_N);
    else npass++;
    ntotal++;
    if ((got64 != SWEEP_N) || (q64.size() != 0))
      $display("[TB] FAIL w64_count: %0d results, %0d pending, expected %0d and 0", got64, q64.size(), SWEEP_N);
    else npass++;
  endtask

  initial begin
    reset = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; tg32 = '0; or32 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; tg16 = '0; or16 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; s64 = 1'b0; tg64 = '0; or64 = 1'b1;
    iv8  = 1'b0; b8  = '0; s8  = '0; tg8  = '0; or8  = 1'b1;
    took16 = 1'b0; took64 = 1'b0;
    for (int g = 0; g < 4; g++) a8[g] = '0;
    $display("[TB] starting karatsuba_mult_pipe bench");
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_w8_exhaustive();
    test_random_sweep();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  // Guard against a hang if the design stops handshaking altogether.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", npass, ntotal);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/karatsuba_mult_pipe.md
Name: karatsuba_mult_pipe

Overview:
- Parametrised, fully pipelined multiplier using a one-level Karatsuba split (three half-width products).
- Generalises the fixed 32-bit unsigned multiplier to any even WIDTH and adds a per-transaction signed/unsigned mode.
- Adds valid/ready handshakes with backpressure and a tag passthrough.
- Sits in the datapath between operand-issue logic and result writeback; accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32: operand width; must be even and >= 4. H = WIDTH/2.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented on A/B/is_signed/in_tag
- in_ready  output  1  block can accept an operation this cycle
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- in_tag  input  TAG_W  tag returned with the result
- out_valid  output  1  result/out_tag valid
- out_ready  input  1  downstream accepts the result this cycle
- result  output  2*WIDTH  product
- out_tag  output  TAG_W  tag of the operation in result

Behaviour:
- Reset:
  - Synchronous, active-high; one cycle with reset=1 clears all stage valid bits.
  - After reset: out_valid=0, result=0, out_tag=0.
  - Reset mid-operation discards all in-flight operations; no partial result is ever emitted.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance, driven combinationally.
  - Accept occurs when in_valid && in_ready.
  - On advance, all three stages shift together. When advance=0, every stage register, including result and out_tag, holds.
  - Bubbles are not collapsed.
  - out_valid stays asserted with result stable until out_ready=1.
- Pipeline: latency 3 cycles from accept to out_valid, with no stalls. Throughput is 1 per cycle with out_ready held high.
  - S1 (on accept):
    - Register sign flags: sA = is_signed & A[WIDTH-1]; sB likewise.
    - Register magnitudes: mA = sA ? -A : A, as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1). mB likewise.
    - Register neg = sA ^ sB, and the tag.
  - S2:
    - Split the magnitudes: a0 = mA[H-1:0], a1 = mA[WIDTH-1:H]; b0 and b1 likewise.
    - Register p0 = a0*b0 and p2 = a1*b1, each 2H bits.
    - Register pm = (a0+a1)*(b0+b1), computing the sums at H+1 bits and pm at 2H+2 bits.
    - Pass neg and the tag.
  - S3:
    - mid = pm - p0 - p2, at 2H+2 bits; always non-negative, no underflow.
    - mag = {p2,p0} + (mid << H), computed at 2*WIDTH bits; carries beyond 2*WIDTH are impossible.
    - Register result = neg ? -mag : mag, as 2*WIDTH-bit two's complement.
    - Register out_tag.
- Width rules:
  - Unsigned mode: result is the exact 2*WIDTH-bit unsigned product.
  - Signed mode: result is the exact 2*WIDTH-bit signed product.
  - A zero magnitude with neg=1 yields 0.
- No internal arithmetic overflow for any operand pair at any legal WIDTH.
- Simultaneous events:
  - The S3 holder draining while a new op is accepted in the same cycle is legal. An output handoff and an input accept may coincide.
  - reset=1 overrides all other inputs.
  - in_valid while in_ready=0 is ignored; the source must hold its inputs.

Test Plan:
- Unsigned corners, WIDTH=32: A=B=0xFFFFFFFF, is_signed=0 -> result 0xFFFFFFFE00000001 exactly 3 cycles after accept. A=0x00010000, B=0x00010000 -> 0x0000000100000000. A=0, B=0xFFFFFFFF -> 0.
- Signed corners:
  - A=B=0xFFFFFFFF, is_signed=1 -> 0x0000000000000001.
  - A=B=0x80000000 -> 0x4000000000000000.
  - A=0x80000000, B=1 -> 0xFFFFFFFF80000000.
  - A=0xFFFFFFFD (-3), B=5 -> 0xFFFFFFFFFFFFFFF1.
- Back-to-back throughput: 8 consecutive accepts with out_ready=1 and tags 0..7 -> 8 consecutive out_valid cycles with results and tags in order, and no gaps.
- Backpressure:
  - Stream 5 ops and drop out_ready for 4 cycles once the first result appears.
  - Required: in_ready=0 during the stall, result and out_tag stable, no loss or duplication, order preserved after out_ready returns.
- Reset mid-operation: accept 2 ops, assert reset for 1 cycle on the next edge -> out_valid=0, result=0, out_tag=0, and neither op ever appears. The next op accepted after reset emerges with correct latency.
- Parametric sweep:
  - WIDTH=8: exhaustive over all 2^16 operand pairs in both modes, against a reference product.
  - WIDTH=16 and WIDTH=64: 10k random ops each, mixed modes, random out_ready.
  - Required: zero mismatches.
